serial_adder: RTL and testbench

//  Parametrised digit-serial adder/subtractor: adds two WIDTH-bit operands DIGIT bits per clock,

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_digit.sv | 26 ++
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding and
// the width helper for the digit counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for NDIG digits: clog2(NDIG), never narrower than one bit.
  function automatic int cnt_width(input int ndig);
    return (ndig <= 2) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells; also
// exposes the carry into its MSB so the caller can form signed overflow.
module adder_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             c_in,
  output logic [DIGIT-1:0] sum,
  output logic             c_out,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock with a
// registered carry, between valid/ready producer and consumer interfaces.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and out_valid/result hold until taken.

  localparam int            NDIG = WIDTH / DIGIT;
  localparam int            CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH % DIGIT != 0) begin : g_width_check
    $error("serial_adder: WIDTH must be a multiple of DIGIT");
  end

  state_t                 state;
  logic [CW-1:0]          count;
  logic [WIDTH-1:0]       a_sr;
  logic [WIDTH-1:0]       b_sr;
  logic [WIDTH-1:0]       res_sr;
  logic                   carry;
  logic [DIGIT-1:0]       d_sum;
  logic                   d_cout;
  logic                   d_cmsb;
  logic [WIDTH+DIGIT-1:0] res_cat;

  adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a     (a_sr[DIGIT-1:0]),
    .b     (b_sr[DIGIT-1:0]),
    .c_in  (carry),
    .sum   (d_sum),
    .c_out (d_cout),
    .c_msb (d_cmsb)
  );

  // New digit enters at the MSB end; works unchanged when DIGIT == WIDTH.
  assign res_cat = {d_sum, res_sr};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      carry     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b ^ {WIDTH{sub}};
            carry    <= c_in ^ sub;
            count    <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_cat[WIDTH+DIGIT-1:DIGIT];
          carry  <= d_cout;
          count  <= count + CW'(1);
          if (count == LAST) begin
            c_out     <= d_cout;
            overflow  <= d_cmsb ^ d_cout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sum       = res_sr;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three configurations (8/1, 8/4, 1/1) checked every
// cycle against an arithmetic reference model, plus literal directed cases.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       chk_en;
  logic       ivld [3];
  logic       irdy [3];
  logic       ovld [3];
  logic       ordy [3];
  logic       cin  [3];
  logic       subv [3];
  logic       co   [3];
  logic       ov   [3];
  logic [7:0] av   [3];
  logic [7:0] bv   [3];
  logic [7:0] sm0;
  logic [7:0] sm1;
  logic [0:0] sm2;
  logic [1:0] dbg0;
  logic [1:0] dbg1;
  logic [1:0] dbg2;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Scoreboard: entry = {overflow, c_out, sum[7:0]}
  logic [9:0] exp_q [3][$];
  logic [9:0] last_res [3];
  logic [9:0] push_v [3];
  logic       push_p [3];
  logic       take_p [3];
  int         due [3];
  logic       rst_p;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(ivld[0]), .in_ready(irdy[0]),
    .a(av[0]), .b(bv[0]), .c_in(cin[0]), .sub(subv[0]),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .sum(sm0),
    .c_out(co[0]), .overflow(ov[0]), .dbg_state(dbg0)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(ivld[1]), .in_ready(irdy[1]),
    .a(av[1]), .b(bv[1]), .c_in(cin[1]), .sub(subv[1]),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .sum(sm1),
    .c_out(co[1]), .overflow(ov[1]), .dbg_state(dbg1)
  );

  serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(ivld[2]), .in_ready(irdy[2]),
    .a(av[2][0:0]), .b(bv[2][0:0]), .c_in(cin[2]), .sub(subv[2]),
    .out_valid(ovld[2]), .out_ready(ordy[2]), .sum(sm2),
    .c_out(co[2]), .overflow(ov[2]), .dbg_state(dbg2)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic int wid(int i);
    return (i == 2) ? 1 : 8;
  endfunction

  function automatic int ndig(int i);
    case (i)
      0:       return 8;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int sum_of(int i);
    case (i)
      0:       return int'(sm0);
      1:       return int'(sm1);
      default: return int'(sm2);
    endcase
  endfunction

  // Reference: plain modular arithmetic for sum/carry, signed range test for overflow.
  function automatic logic [9:0] model(int w, int a, int b, int c, int s);
    int mask, half, u, sa, sb, t;
    logic [9:0] r;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    if (s == 0) u = a + b + c;
    else        u = a + ((~b) & mask) + (1 - c);
    sa = (a >= half) ? a - (1 << w) : a;
    sb = (b >= half) ? b - (1 << w) : b;
    t  = (s == 0) ? sa + sb + c : sa - sb - c;
    r       = '0;
    r[7:0]  = 8'(u & mask);
    r[8]    = ((u >> w) & 1) != 0;
    r[9]    = (t < -half) || (t > half - 1);
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic [9:0] e;
        logic       ev;
        int         mask;
        if (rst_p) begin
          exp_q[i].delete();
          last_res[i] = '0;
          take_p[i]   = 1'b0;
          push_p[i]   = 1'b0;
        end else begin
          if (take_p[i]) begin
            last_res[i] = exp_q[i].pop_front();
            take_p[i]   = 1'b0;
          end
          if (push_p[i]) begin
            exp_q[i].push_back(push_v[i]);
            due[i]    = cyc + ndig(i);
            push_p[i] = 1'b0;
          end
        end
        ev = (exp_q[i].size() != 0) && (cyc >= due[i]);
        chk($sformatf("in_ready[%0d]", i), int'(irdy[i]), int'(exp_q[i].size() == 0));
        chk($sformatf("out_valid[%0d]", i), int'(ovld[i]), int'(ev));
        if (ev || exp_q[i].size() == 0) begin
          e = ev ? exp_q[i][0] : last_res[i];
          chk($sformatf("sum[%0d]", i), sum_of(i), int'(e[7:0]));
          chk($sformatf("c_out[%0d]", i), int'(co[i]), int'(e[8]));
          chk($sformatf("overflow[%0d]", i), int'(ov[i]), int'(e[9]));
        end
        if (!rst) begin
          if (ev && ordy[i]) take_p[i] = 1'b1;
          if (exp_q[i].size() == 0 && ivld[i]) begin
            mask      = (1 << wid(i)) - 1;
            push_p[i] = 1'b1;
            push_v[i] = model(wid(i), int'(av[i]) & mask, int'(bv[i]) & mask,
                              int'(cin[i]), int'(subv[i]));
          end
        end
      end
    end
    rst_p = rst;
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(int i, int a, int b, int c, int s);
    av[i]   = 8'(a);
    bv[i]   = 8'(b);
    cin[i]  = 1'(c);
    subv[i] = 1'(s);
    ivld[i] = 1'b1;
    @(posedge clk); #1;
    ivld[i] = 1'b0;
    av[i]   = 8'($urandom);
    bv[i]   = 8'($urandom);
    cin[i]  = 1'($urandom);
    subv[i] = 1'($urandom);
  endtask

  task automatic wait_valid(int i, output int n);
    n = 0;
    while (!ovld[i] && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic lit_op(int i, int a, int b, int c, int s, int es, int eco, int eov);
    int n;
    start_op(i, a, b, c, s);
    wait_valid(i, n);
    chk($sformatf("latency[%0d]", i), n, ndig(i));
    chk($sformatf("lit_sum[%0d]", i), sum_of(i), es);
    chk($sformatf("lit_c_out[%0d]", i), int'(co[i]), eco);
    chk($sformatf("lit_overflow[%0d]", i), int'(ov[i]), eov);
    @(posedge clk); #1;
    chk($sformatf("valid_drop[%0d]", i), int'(ovld[i]), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, tot, ea, eb, ec;
    rst    = 1'b1;
    chk_en = 1'b0;
    rst_p  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ivld[i] = 1'b0; ordy[i] = 1'b1; av[i] = '0; bv[i] = '0;
      cin[i] = 1'b0; subv[i] = 1'b0; push_p[i] = 1'b0; take_p[i] = 1'b0;
      last_res[i] = '0; due[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_in_ready", int'(irdy[i]), 1);
      chk("reset_out_valid", int'(ovld[i]), 0);
      chk("reset_sum", sum_of(i), 0);
      chk("reset_c_out", int'(co[i]), 0);
      chk("reset_overflow", int'(ov[i]), 0);
    end

    lit_op(0, 'h5A, 'h33, 0, 0, 'h8D, 0, 1);
    lit_op(0, 'hFF, 'h01, 1, 0, 'h01, 1, 0);
    lit_op(1, 'h10, 'h20, 0, 1, 'hF0, 0, 0);
    lit_op(1, 'h80, 'h01, 0, 1, 'h7F, 1, 1);

    // Single full-adder cell: overflow is carry-in XOR carry-out.
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 8; v++) begin
        ea  = (v >> 2) & 1;
        eb  = (v >> 1) & 1;
        ec  = v & 1;
        tot = (s == 0) ? ea + eb + ec : ea + (1 - eb) + (1 - ec);
        lit_op(2, ea, eb, ec, s, tot & 1, tot >> 1,
               ((s == 0) ? ec : 1 - ec) ^ (tot >> 1));
      end
    end

    // Backpressure: result held while out_ready is low; new operands ignored.
    ordy[0] = 1'b0;
    start_op(0, 'h12, 'h34, 0, 0);
    wait_valid(0, n);
    chk("bp_latency", n, 8);
    repeat (5) begin
      chk("bp_valid", int'(ovld[0]), 1);
      chk("bp_sum", sum_of(0), 'h46);
      chk("bp_in_ready", int'(irdy[0]), 0);
      av[0] = 8'($urandom); bv[0] = 8'($urandom); ivld[0] = 1'b1;
      @(posedge clk); #1;
    end
    ivld[0] = 1'b0;
    chk("bp_valid_end", int'(ovld[0]), 1);
    chk("bp_sum_end", sum_of(0), 'h46);
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", int'(ovld[0]), 0);
    chk("bp_release_ready", int'(irdy[0]), 1);
    lit_op(0, 'hC8, 'h64, 1, 1, 'h63, 1, 1);

    // Abort mid-RUN after three digits.
    start_op(0, 'hB7, 'h6E, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_valid", int'(ovld[0]), 0);
    chk("abort_ready", int'(irdy[0]), 1);
    chk("abort_sum", sum_of(0), 0);
    lit_op(0, 'h0F, 'h01, 0, 0, 'h10, 0, 0);

    // Random traffic on all three configurations, one reset in the middle.
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 3; i++) begin
        ivld[i] = ($urandom_range(0, 3) != 0);
        ordy[i] = ($urandom_range(0, 3) != 0);
        av[i]   = 8'($urandom);
        bv[i]   = 8'($urandom);
        cin[i]  = 1'($urandom_range(0, 1));
        subv[i] = 1'($urandom_range(0, 1));
      end
      rst = (k == 700);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ivld[i] = 1'b0;
      ordy[i] = 1'b1;
    end
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk("drain_idle", int'(irdy[i]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
